rtc_bus_sched: RTL and testbench

RTC_BUS_SCHED -- requirements
Module: rtc_bus_sched

---
 rtl/rtc_bus_sched_if.sv | 31 +++
 rtl/rtc_bus_sched.sv | 159 +++++++++++++++
 tb/tb_rtc_bus_sched.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_sched_if.sv
// Bundle of requester handshake and RTC bus signals for rtc_bus_sched.
interface rtc_bus_sched_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NREQ       = 4
);
  logic [NREQ-1:0]            req;
  logic [NREQ-1:0]            req_rw;
  logic [NREQ*DATA_WIDTH-1:0] req_addr;
  logic [NREQ*DATA_WIDTH-1:0] req_wdata;
  logic                       hold;
  logic [DATA_WIDTH-1:0]      ad_in;
  logic [NREQ-1:0]            gnt;
  logic                       done;
  logic [DATA_WIDTH-1:0]      rdata;
  logic                       busy;
  logic [3:0]                 control;
  logic [DATA_WIDTH-1:0]      ad_out;
  logic                       ad_oe;

  // Requester / bus-environment side
  modport master (
    output req, req_rw, req_addr, req_wdata, hold, ad_in,
    input  gnt, done, rdata, busy, control, ad_out, ad_oe
  );

  // Scheduler side
  modport slave (
    input  req, req_rw, req_addr, req_wdata, hold, ad_in,
    output gnt, done, rdata, busy, control, ad_out, ad_oe
  );
endinterface

// File: rtl/rtc_bus_sched.sv
// Round-robin scheduler that serialises requester transactions onto a
// multiplexed RTC address/data bus using a fixed 42-cycle frame.
module rtc_bus_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int NREQ       = 4
) (
  input  logic           clk,
  input  logic           reset,
  rtc_bus_sched_if.slave bus
);

  localparam int PW = $clog2(NREQ);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FRAME = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [5:0] CNT_LAST = 6'd41;
  localparam logic [5:0] CNT_CAP  = 6'd31;

  // control = {CS, AD, RD, WR}
  localparam logic [3:0] CTL_IDLE = 4'b1101;
  localparam logic [3:0] CTL_GAP  = 4'b1001;
  localparam logic [3:0] CTL_ADDR = 4'b0010;
  localparam logic [3:0] CTL_WR   = 4'b0110;
  localparam logic [3:0] CTL_RD   = 4'b0101;

  logic [1:0]            state;
  logic [5:0]            cnt;
  logic [PW-1:0]         rr;
  logic [PW-1:0]         widx;
  logic                  rw_l;
  logic [DATA_WIDTH-1:0] addr_l;
  logic [DATA_WIDTH-1:0] wdata_l;

  logic                  pick_valid;
  logic [PW-1:0]         pick;
  logic [PW-1:0]         idx;

  logic [3:0]            nxt_ctl;
  logic                  nxt_oe;
  logic [DATA_WIDTH-1:0] nxt_ad;

  // Round-robin search: first active request at or after rr, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    idx        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = rr + PW'(k);
      if (!pick_valid && bus.req[idx]) begin
        pick_valid = 1'b1;
        pick       = idx;
      end
    end
  end

  // Bus phase decode from the frame counter and latched direction.
  always_comb begin
    nxt_ctl = CTL_IDLE;
    nxt_oe  = 1'b0;
    nxt_ad  = '0;
    if (cnt <= 6'd3) begin
      nxt_ctl = CTL_IDLE;
    end else if (cnt <= 6'd5) begin
      nxt_ctl = CTL_GAP;
    end else if (cnt <= 6'd11) begin
      nxt_ctl = CTL_ADDR;
      nxt_oe  = 1'b1;
      nxt_ad  = addr_l;
    end else if (cnt <= 6'd13) begin
      nxt_ctl = CTL_GAP;
    end else if (cnt <= 6'd25) begin
      nxt_ctl = CTL_IDLE;
    end else if (cnt <= CNT_CAP) begin
      if (rw_l) begin
        nxt_ctl = CTL_WR;
        nxt_oe  = 1'b1;
        nxt_ad  = wdata_l;
      end else begin
        nxt_ctl = CTL_RD;
      end
    end else begin
      nxt_ctl = CTL_IDLE;
    end
  end

  // Frame sequencing: arbitration, operand latching, counting, completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rr        <= '0;
      widx      <= '0;
      rw_l      <= 1'b0;
      addr_l    <= '0;
      wdata_l   <= '0;
      bus.gnt   <= '0;
      bus.done  <= 1'b0;
      bus.busy  <= 1'b0;
      bus.rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!bus.hold && pick_valid) begin
            state    <= ST_FRAME;
            cnt      <= '0;
            widx     <= pick;
            rw_l     <= bus.req_rw[pick];
            addr_l   <= bus.req_addr[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
            wdata_l  <= bus.req_wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
            bus.gnt  <= NREQ'(1) << pick;
            bus.busy <= 1'b1;
          end
        end
        ST_FRAME: begin
          if (cnt == CNT_CAP && !rw_l) begin
            bus.rdata <= bus.ad_in;
          end
          if (cnt == CNT_LAST) begin
            state    <= ST_DONE;
            bus.done <= 1'b1;
            rr       <= widx + PW'(1);
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          cnt      <= '0;
          bus.done <= 1'b0;
          bus.gnt  <= '0;
          bus.busy <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered bus strobes: one cycle behind cnt, parked outside FRAME.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.control <= CTL_IDLE;
      bus.ad_out  <= '0;
      bus.ad_oe   <= 1'b0;
    end else if (state == ST_FRAME) begin
      bus.control <= nxt_ctl;
      bus.ad_out  <= nxt_ad;
      bus.ad_oe   <= nxt_oe;
    end else begin
      bus.control <= CTL_IDLE;
      bus.ad_out  <= '0;
      bus.ad_oe   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rtc_bus_sched.sv
// Directed bench for rtc_bus_sched: write, read, hold, round-robin,
// mid-frame reset and request drop.
module tb_rtc_bus_sched;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [3:0] eg;
  int   j;

  rtc_bus_sched_if #(.DATA_WIDTH(8), .NREQ(4)) bus ();

  rtc_bus_sched #(.DATA_WIDTH(8), .NREQ(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the arbitration edge; walks the whole frame.
  // k counts edges after frame start, so after edge k the strobes show cnt=k-1.
  task automatic frame(input string nm, input logic [3:0] xg, input logic wr,
                       input logic [7:0] xa, input logic [7:0] xd, input logic [7:0] xr,
                       input logic [3:0] mreq, input logic mhold, input logic scr);
    check({nm, ":gnt0"}, 32'(bus.gnt), 32'(xg));
    check({nm, ":busy0"}, 32'(bus.busy), 32'd1);
    check({nm, ":ctl0"}, 32'(bus.control), 32'b1101);
    for (int k = 1; k <= 42; k++) begin
      tick();
      if (k == 10) begin
        bus.req  = mreq;
        bus.hold = mhold;
        if (scr) begin
          bus.req_addr  = 32'hA5A5A5A5;
          bus.req_wdata = 32'h5A5A5A5A;
        end
      end
      if (k == 32) bus.ad_in = ~bus.ad_in;
      if (k == 6 || k == 13) begin
        check({nm, ":gap_ctl"}, 32'(bus.control), 32'b1001);
        check({nm, ":gap_oe"}, 32'(bus.ad_oe), 32'd0);
      end
      if (k == 7 || k == 12) begin
        check({nm, ":addr_ctl"}, 32'(bus.control), 32'b0010);
        check({nm, ":addr_oe"}, 32'(bus.ad_oe), 32'd1);
        check({nm, ":addr_ad"}, 32'(bus.ad_out), 32'(xa));
      end
      if (k == 27 || k == 32) begin
        if (wr) begin
          check({nm, ":wdat_ctl"}, 32'(bus.control), 32'b0110);
          check({nm, ":wdat_oe"}, 32'(bus.ad_oe), 32'd1);
          check({nm, ":wdat_ad"}, 32'(bus.ad_out), 32'(xd));
        end else begin
          check({nm, ":rdat_ctl"}, 32'(bus.control), 32'b0101);
          check({nm, ":rdat_oe"}, 32'(bus.ad_oe), 32'd0);
        end
      end
      if (k == 33) check({nm, ":post_ctl"}, 32'(bus.control), 32'b1101);
      if (k == 41) check({nm, ":done_early"}, 32'(bus.done), 32'd0);
      if (k == 42) begin
        check({nm, ":done"}, 32'(bus.done), 32'd1);
        check({nm, ":busy_done"}, 32'(bus.busy), 32'd1);
        check({nm, ":gnt_done"}, 32'(bus.gnt), 32'(xg));
        check({nm, ":rdata"}, 32'(bus.rdata), 32'(xr));
      end
    end
    tick();
    check({nm, ":gnt_end"}, 32'(bus.gnt), 32'd0);
    check({nm, ":done_end"}, 32'(bus.done), 32'd0);
    check({nm, ":busy_end"}, 32'(bus.busy), 32'd0);
    check({nm, ":ctl_end"}, 32'(bus.control), 32'b1101);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.req       = '0;
    bus.req_rw    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.hold      = 1'b0;
    bus.ad_in     = '0;
    repeat (2) tick();

    // Reset state
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_ctl", 32'(bus.control), 32'b1101);
    check("rst_ad", 32'(bus.ad_out), 32'd0);
    check("rst_oe", 32'(bus.ad_oe), 32'd0);
    reset = 1'b0;

    // Single write on requester 0; req dropped and operands scrambled at cnt=10
    bus.req       = 4'b0001;
    bus.req_rw    = 4'b0001;
    bus.req_addr  = 32'h0000000F;
    bus.req_wdata = 32'h00000018;
    tick();
    frame("wr", 4'b0001, 1'b1, 8'h0F, 8'h18, 8'h00, 4'b0000, 1'b0, 1'b1);
    tick();
    check("drop_nognt", 32'(bus.gnt), 32'd0);
    check("drop_nobusy", 32'(bus.busy), 32'd0);

    // Single read on requester 2; hold raised mid-frame must not abort it
    bus.req       = 4'b0100;
    bus.req_rw    = 4'b0000;
    bus.req_addr  = 32'h00210000;
    bus.ad_in     = 8'h5A;
    tick();
    frame("rd", 4'b0100, 1'b0, 8'h21, 8'h00, 8'h5A, 4'b0000, 1'b1, 1'b0);

    // Hold blocks arbitration; a write then leaves rdata unchanged
    bus.req       = 4'b0010;
    bus.req_rw    = 4'b0010;
    bus.req_addr  = 32'h00004400;
    bus.req_wdata = 32'h00003300;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_gnt", 32'(bus.gnt), 32'd0);
      check("hold_ctl", 32'(bus.control), 32'b1101);
    end
    bus.hold = 1'b0;
    tick();
    frame("hd", 4'b0010, 1'b1, 8'h44, 8'h33, 8'h5A, 4'b0000, 1'b0, 1'b0);

    // Round robin from reset with all requesters active
    reset = 1'b1;
    #2;
    reset = 1'b0;
    bus.req       = 4'b1111;
    bus.req_rw    = 4'b1111;
    bus.req_addr  = 32'h13121110;
    bus.req_wdata = 32'h23222120;
    for (int i = 0; i < 5; i++) begin
      j  = i % 4;
      eg = 4'b0001 << j;
      tick();
      frame("rr", eg, 1'b1, 8'(8'h10 + j), 8'(8'h20 + j), 8'h00,
            (i == 4) ? 4'b0000 : 4'b1111, 1'b0, 1'b0);
    end

    // Reset in ADDR phase, then priority restarts at requester 0
    bus.req       = 4'b1000;
    bus.req_rw    = 4'b1000;
    bus.req_addr  = 32'h7700000F;
    bus.req_wdata = 32'h66000018;
    tick();
    check("mrst_gnt", 32'(bus.gnt), 32'b1000);
    repeat (8) tick();
    check("mrst_pre_oe", 32'(bus.ad_oe), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("mrst_gnt0", 32'(bus.gnt), 32'd0);
    check("mrst_oe0", 32'(bus.ad_oe), 32'd0);
    check("mrst_ctl", 32'(bus.control), 32'b1101);
    check("mrst_busy", 32'(bus.busy), 32'd0);
    #1 reset = 1'b0;
    bus.req    = 4'b1001;
    bus.req_rw = 4'b1001;
    tick();
    frame("mrst0", 4'b0001, 1'b1, 8'h0F, 8'h18, 8'h00, 4'b1000, 1'b0, 1'b0);
    tick();
    frame("mrst3", 4'b1000, 1'b1, 8'h77, 8'h66, 8'h00, 4'b0000, 1'b0, 1'b0);
    tick();
    check("final_idle", 32'(bus.gnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
